// File: rtl/sub20win_pipe_pkg.sv
// rtl/sub20win_pipe_pkg.sv - shared widths and types for the 20-bit window subtractor
// Optional feature macro used by the top: SUB20WIN_SAT_EN
package sub20win_pkg;

   localparam int WIDTH_DEF = 19;
   localparam int LO_W_DEF  = 10;
   localparam int HI_W      = WIDTH_DEF + 1 - LO_W_DEF;

   typedef logic [WIDTH_DEF:0] word_t;

   typedef struct packed {
      logic [LO_W_DEF-1:0] lo_diff;
      logic                lo_borrow;
      logic [HI_W-1:0]     a_hi;
      logic [HI_W-1:0]     b_hi;
   } s1_t;

endpackage

// File: rtl/sub20win_pipe_if.sv
// rtl/sub20win_pipe_if.sv - operand/result stream bundle with valid/ready handshakes
interface sub20win_pipe_if #(
   parameter int WIDTH = sub20win_pkg::WIDTH_DEF
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH:0]   A;
   logic [WIDTH:0]   B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out;
   logic             borrow;

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, out, borrow
   );

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, out, borrow
   );

endinterface

// File: rtl/sub20win_pipe_sub_slice.sv
// rtl/sub20win_pipe_sub_slice.sv - N-bit ripple-borrow subtract slice, d = a - b - bin
module sub_slice #(
   parameter int N = 10
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic [N-1:0] d,
   output logic         bout
);

   logic [N:0] bw;

   always_comb begin
      bw    = '0;
      d     = '0;
      bw[0] = bin;
      for (int i = 0; i < N; i++) begin
         d[i]    = a[i] ^ b[i] ^ bw[i];
         bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
      end
      bout = bw[N];
   end

endmodule

// File: rtl/sub20win_pipe.sv
// rtl/sub20win_pipe.sv - two-stage pipelined 20-bit subtractor, low slice then high slice
// SUB20WIN_SAT_EN: clamp an underflowing result to zero (borrow still reported)
module sub20win_pipe
   import sub20win_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   sub20win_pipe_if.slave  bus
);

   s1_t   s1_q, s1_d;
   word_t out_q, out_d;
   logic  s1_valid_q, s1_valid_d;
   logic  s2_valid_q, s2_valid_d;
   logic  borrow_q, borrow_d;

   logic                lo_bout, hi_bout;
   logic [LO_W_DEF-1:0] lo_d;
   logic [HI_W-1:0]     hi_d;
   logic                s2_adv, in_ready, accept;
   word_t               res;

   sub_slice #(.N(LO_W_DEF)) u_lo (
      .a    (bus.A[LO_W_DEF-1:0]),
      .b    (bus.B[LO_W_DEF-1:0]),
      .bin  (1'b0),
      .d    (lo_d),
      .bout (lo_bout)
   );

   sub_slice #(.N(HI_W)) u_hi (
      .a    (s1_q.a_hi),
      .b    (s1_q.b_hi),
      .bin  (s1_q.lo_borrow),
      .d    (hi_d),
      .bout (hi_bout)
   );

   always_comb begin
      s2_adv     = s1_valid_q & (~s2_valid_q | bus.out_ready);
      in_ready   = ~s1_valid_q | s2_adv;
      accept     = bus.in_valid & in_ready;
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      out_d      = out_q;
      borrow_d   = borrow_q;
      s2_valid_d = s2_valid_q;
      res        = {hi_d, s1_q.lo_diff};
`ifdef SUB20WIN_SAT_EN
      if (hi_bout) res = '0;
`endif
      if (accept) begin
         s1_d.lo_diff   = lo_d;
         s1_d.lo_borrow = lo_bout;
         s1_d.a_hi      = bus.A[WIDTH_DEF:LO_W_DEF];
         s1_d.b_hi      = bus.B[WIDTH_DEF:LO_W_DEF];
         s1_valid_d     = 1'b1;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end
      // Stage 2 reloads on advance; otherwise it empties only when the result is taken
      if (s2_adv) begin
         out_d      = res;
         borrow_d   = hi_bout;
         s2_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s1_valid_q <= 1'b0;
         out_q      <= '0;
         borrow_q   <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s1_valid_q <= s1_valid_d;
         out_q      <= out_d;
         borrow_q   <= borrow_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out       = out_q;
   assign bus.borrow    = borrow_q;

endmodule
